// File: rtl/conv1d_output_packer_if.sv
// Quant-result ingress and CPU-side FIFO drain bundle for the
// conv1d output packer.
interface conv1d_output_packer_if #(
    parameter int INT32_SIZE = 32,
    parameter int FIFO_DEPTH = 64,
    parameter int LEVEL_W    = $clog2(FIFO_DEPTH) + 1
);
    logic                  clear;
    logic                  in_valid;
    logic                  in_ready;
    logic [INT32_SIZE-1:0] in_data;
    logic                  flush;
    logic                  pop;
    logic [INT32_SIZE-1:0] out_data;
    logic                  out_valid;
    logic [LEVEL_W-1:0]    level;
    logic [1:0]            lane;
    logic                  clip;
    logic                  underflow;

    modport master (
        output clear, in_valid, in_data, flush, pop,
        input  in_ready, out_data, out_valid, level,
        input  lane, clip, underflow
    );

    modport slave (
        input  clear, in_valid, in_data, flush, pop,
        output in_ready, out_data, out_valid, level,
        output lane, clip, underflow
    );
endinterface

// File: rtl/conv1d_output_packer.sv
// Saturates int8 results, packs four per 32-bit word little-endian
// and buffers the words in a first-word-fall-through FIFO.
module conv1d_output_packer #(
    parameter int INT32_SIZE = 32,
    parameter int BYTE_SIZE  = 8,
    parameter int FIFO_DEPTH = 64,
    parameter int LEVEL_W    = $clog2(FIFO_DEPTH) + 1
) (
    input logic                    clk,
    input logic                    rst,
    conv1d_output_packer_if.slave  bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int SH_W  = $clog2(INT32_SIZE);
    localparam logic [LEVEL_W-1:0] FULL_LVL = LEVEL_W'(FIFO_DEPTH);
    localparam logic signed [INT32_SIZE-1:0] B_MAX =
        INT32_SIZE'((1 << (BYTE_SIZE - 1)) - 1);
    localparam logic signed [INT32_SIZE-1:0] B_MIN = -B_MAX - 1;

    logic [INT32_SIZE-1:0] mem_q [FIFO_DEPTH];

    logic [1:0]            lane_q, lane_d;
    logic [INT32_SIZE-1:0] pack_q, pack_d;
    logic                  pend_q, pend_d;
    logic                  clip_q, clip_d;
    logic                  under_q, under_d;
    logic [LEVEL_W-1:0]    level_q, level_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [INT32_SIZE-1:0] hold_q, hold_d;

    logic signed [INT32_SIZE-1:0] sin;
    logic [BYTE_SIZE-1:0]  byte_sat;
    logic                  sat_hit;
    logic [SH_W-1:0]       shamt;
    logic [INT32_SIZE-1:0] merged;
    logic                  full;
    logic                  non_empty;
    logic                  ready;
    logic                  accept;
    logic                  pop_ok;
    logic                  push;
    logic [INT32_SIZE-1:0] push_word;

    always_comb begin
        sin      = $signed(bus.in_data);
        byte_sat = sin[BYTE_SIZE-1:0];
        sat_hit  = 1'b0;
        if (sin > B_MAX) begin
            byte_sat = B_MAX[BYTE_SIZE-1:0];
            sat_hit  = 1'b1;
        end else if (sin < B_MIN) begin
            byte_sat = B_MIN[BYTE_SIZE-1:0];
            sat_hit  = 1'b1;
        end
    end

    assign shamt     = SH_W'(lane_q) * SH_W'(BYTE_SIZE);
    assign merged    = pack_q | (INT32_SIZE'(byte_sat) << shamt);
    assign full      = (level_q == FULL_LVL);
    assign non_empty = (level_q != '0);
    assign ready     = !(lane_q == 2'd3 && full) && !pend_q;
    assign accept    = bus.in_valid && ready;

    always_comb begin
        lane_d    = lane_q;
        pack_d    = pack_q;
        pend_d    = pend_q;
        clip_d    = clip_q;
        under_d   = under_q;
        level_d   = level_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        hold_d    = hold_q;
        push      = 1'b0;
        push_word = merged;
        pop_ok    = bus.pop && non_empty;

        if (accept) begin
            clip_d = clip_q | sat_hit;
            if (lane_q == 2'd3) begin
                push   = 1'b1;
                lane_d = 2'd0;
                pack_d = '0;
            end else begin
                lane_d = lane_q + 2'd1;
                pack_d = merged;
            end
        end

        // A flush blocked by a full FIFO is retried every cycle.
        if ((bus.flush || pend_q) && !push && lane_d != 2'd0) begin
            if (!full) begin
                push      = 1'b1;
                push_word = pack_d;
                lane_d    = 2'd0;
                pack_d    = '0;
                pend_d    = 1'b0;
            end else begin
                pend_d = 1'b1;
            end
        end else begin
            pend_d = 1'b0;
        end

        if (bus.pop && !non_empty) under_d = 1'b1;
        if (pop_ok) begin
            hold_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);

        unique case ({push, pop_ok})
            2'b10:   level_d = level_q + LEVEL_W'(1);
            2'b01:   level_d = level_q - LEVEL_W'(1);
            default: level_d = level_q;
        endcase

        if (bus.clear) begin
            lane_d   = 2'd0;
            pack_d   = '0;
            pend_d   = 1'b0;
            clip_d   = 1'b0;
            under_d  = 1'b0;
            level_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            hold_d   = '0;
            push     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane_q   <= 2'd0;
            pack_q   <= '0;
            pend_q   <= 1'b0;
            clip_q   <= 1'b0;
            under_q  <= 1'b0;
            level_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            hold_q   <= '0;
        end else begin
            lane_q   <= lane_d;
            pack_q   <= pack_d;
            pend_q   <= pend_d;
            clip_q   <= clip_d;
            under_q  <= under_d;
            level_q  <= level_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            hold_q   <= hold_d;
        end
    end

    // Storage needs no reset: it is only visible through valid entries.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_word;
    end

    assign bus.in_ready  = ready;
    assign bus.out_valid = non_empty;
    assign bus.out_data  = non_empty ? mem_q[rd_ptr_q] : hold_q;
    assign bus.level     = level_q;
    assign bus.lane      = lane_q;
    assign bus.clip      = clip_q;
    assign bus.underflow = under_q;

endmodule

// File: tb/tb_conv1d_output_packer.sv
// Directed bench for conv1d_output_packer with hand-computed
// expected words, flags and FIFO levels.
module tb_conv1d_output_packer;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   rd_cnt;
    int   peak;

    conv1d_output_packer_if #(
        .INT32_SIZE(32), .FIFO_DEPTH(64), .LEVEL_W(7)
    ) bus ();

    conv1d_output_packer #(
        .INT32_SIZE(32), .BYTE_SIZE(8),
        .FIFO_DEPTH(64), .LEVEL_W(7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sx(input logic [7:0] b);
        return {{24{b[7]}}, b};
    endfunction

    function automatic logic [31:0] wexp(input int n);
        return {8'(4*n+3), 8'(4*n+2), 8'(4*n+1), 8'(4*n)};
    endfunction

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        bus.clear = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.flush = 1'b0;
        bus.pop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_lane", bus.lane, 0);
        chk("rst_flags", {bus.clip, bus.underflow}, 0);
        rst = 1'b0;
        step();

        // four back-to-back bytes
        bus.in_valid = 1'b1;
        bus.in_data = 32'd1; step();
        bus.in_data = 32'd2; step();
        bus.in_data = 32'd3; step();
        bus.in_data = 32'd4; step();
        bus.in_valid = 1'b0;
        chk("pack_valid", bus.out_valid, 1);
        chk("pack_data", bus.out_data, 32'h04030201);
        chk("pack_level", bus.level, 1);
        chk("pack_lane", bus.lane, 0);
        bus.pop = 1'b1; step(); bus.pop = 1'b0;
        chk("pop_valid", bus.out_valid, 0);
        chk("pop_level", bus.level, 0);

        // saturation and flush of a partial word
        bus.in_valid = 1'b1;
        bus.in_data = 32'd300; step();
        bus.in_data = -32'sd200; step();
        bus.in_data = 32'd5; step();
        bus.in_valid = 1'b0;
        chk("sat_lane3", bus.lane, 3);
        chk("sat_noclip_push", bus.level, 0);
        bus.flush = 1'b1; step(); bus.flush = 1'b0;
        chk("flush_data", bus.out_data, 32'h0005807F);
        chk("flush_clip", bus.clip, 1);
        chk("flush_lane", bus.lane, 0);
        chk("flush_level", bus.level, 1);
        bus.pop = 1'b1; step(); bus.pop = 1'b0;

        // flush coinciding with the completing byte is a no-op
        bus.in_valid = 1'b1;
        bus.in_data = 32'h11; step();
        bus.in_data = 32'h22; step();
        bus.in_data = 32'h33; step();
        bus.in_data = 32'h44; bus.flush = 1'b1; step();
        bus.in_valid = 1'b0; bus.flush = 1'b0;
        chk("fcomp_data", bus.out_data, 32'h44332211);
        chk("fcomp_level", bus.level, 1);
        step();
        chk("fcomp_noextra", bus.level, 1);
        bus.pop = 1'b1; step(); bus.pop = 1'b0;
        bus.flush = 1'b1; step(); bus.flush = 1'b0;
        chk("flush_lane0_noop", bus.level, 0);

        // fill all 64 entries
        bus.in_valid = 1'b1;
        for (int w = 0; w < 64; w++)
            for (int k = 0; k < 4; k++) begin
                bus.in_data = sx(8'(4*w+k));
                step();
            end
        bus.in_valid = 1'b0;
        chk("fill_level", bus.level, 64);
        chk("fill_head", bus.out_data, 32'h03020100);
        for (int k = 0; k < 3; k++) begin
            chk("full_ready_lo", bus.in_ready, 1);
            bus.in_valid = 1'b1;
            bus.in_data = sx(8'(8'hA0 + k));
            step();
        end
        chk("full_lane3", bus.lane, 3);
        chk("full_ready3", bus.in_ready, 0);
        bus.in_data = sx(8'hA3); step();
        chk("full_blocked", bus.lane, 3);
        chk("full_blk_level", bus.level, 64);
        bus.pop = 1'b1; step(); bus.pop = 1'b0;
        chk("full_pop_level", bus.level, 63);
        chk("full_pop_ready", bus.in_ready, 1);
        chk("full_pop_head", bus.out_data, 32'h07060504);
        step();
        bus.in_valid = 1'b0;
        chk("full_4th_level", bus.level, 64);
        chk("full_4th_lane", bus.lane, 0);

        // flush pending while full
        bus.in_valid = 1'b1;
        bus.in_data = sx(8'hB0); step();
        bus.in_data = sx(8'hB1); step();
        bus.in_valid = 1'b0;
        chk("pend_lane2", bus.lane, 2);
        chk("pend_ready_pre", bus.in_ready, 1);
        bus.flush = 1'b1; step(); bus.flush = 1'b0;
        chk("pend_ready", bus.in_ready, 0);
        chk("pend_level", bus.level, 64);
        chk("pend_lane_kept", bus.lane, 2);
        bus.pop = 1'b1; step(); bus.pop = 1'b0;
        chk("pend_pop_level", bus.level, 63);
        chk("pend_pop_ready", bus.in_ready, 0);
        step();
        chk("pend_push_level", bus.level, 64);
        chk("pend_push_ready", bus.in_ready, 1);
        chk("pend_push_lane", bus.lane, 0);
        bus.pop = 1'b1;
        repeat (62) step();
        bus.pop = 1'b0;
        chk("drain_word65", bus.out_data, 32'hA3A2A1A0);
        chk("drain_level2", bus.level, 2);
        bus.pop = 1'b1; step();
        chk("drain_partial", bus.out_data, 32'h0000B1B0);
        step(); bus.pop = 1'b0;
        chk("drain_empty", bus.out_valid, 0);
        chk("drain_hold", bus.out_data, 32'h0000B1B0);
        chk("drain_no_uf", bus.underflow, 0);

        // underflow
        bus.pop = 1'b1; step(); bus.pop = 1'b0;
        chk("uf_flag", bus.underflow, 1);
        chk("uf_level", bus.level, 0);

        // stream 130 words across pointer wrap
        rd_cnt = 0;
        peak = 0;
        for (int c = 0; c < 520; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data = sx(8'(c));
            if (bus.out_valid) begin
                chk("stream_order", bus.out_data, wexp(rd_cnt));
                bus.pop = 1'b1;
                rd_cnt++;
            end else begin
                bus.pop = 1'b0;
            end
            step();
            if (int'(bus.level) > peak) peak = int'(bus.level);
        end
        bus.in_valid = 1'b0;
        bus.pop = 1'b0;
        if (bus.out_valid) begin
            chk("stream_order", bus.out_data, wexp(rd_cnt));
            bus.pop = 1'b1;
            rd_cnt++;
        end
        step();
        bus.pop = 1'b0;
        chk("stream_count", rd_cnt, 130);
        chk("stream_peak", peak, 1);
        chk("stream_level", bus.level, 0);

        // asynchronous reset mid-operation
        bus.in_valid = 1'b1;
        for (int c = 0; c < 42; c++) begin
            bus.in_data = sx(8'(c));
            step();
        end
        bus.in_valid = 1'b0;
        chk("arst_pre_level", bus.level, 10);
        chk("arst_pre_lane", bus.lane, 2);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_level", bus.level, 0);
        chk("arst_lane", bus.lane, 0);
        chk("arst_valid", bus.out_valid, 0);
        chk("arst_data", bus.out_data, 0);
        chk("arst_flags", {bus.clip, bus.underflow}, 0);
        chk("arst_ready", bus.in_ready, 1);
        step();
        rst = 1'b0;

        // clear wins over in_valid, flush and pop
        bus.pop = 1'b1; step(); bus.pop = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data = 32'sd1000;
        repeat (5) step();
        bus.in_valid = 1'b0;
        chk("clr_pre_level", bus.level, 1);
        chk("clr_pre_flags", {bus.clip, bus.underflow}, 2'b11);
        bus.clear = 1'b1;
        bus.in_valid = 1'b1;
        bus.flush = 1'b1;
        bus.pop = 1'b1;
        step();
        bus.clear = 1'b0;
        bus.in_valid = 1'b0;
        bus.flush = 1'b0;
        bus.pop = 1'b0;
        chk("clr_level", bus.level, 0);
        chk("clr_lane", bus.lane, 0);
        chk("clr_valid", bus.out_valid, 0);
        chk("clr_data", bus.out_data, 0);
        chk("clr_flags", {bus.clip, bus.underflow}, 0);
        chk("clr_ready", bus.in_ready, 1);
        step();
        chk("clr_nopush", bus.level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv1d_output_packer.md
Name: conv1d_output_packer

Overview:
- Downstream stage of the conv1d accelerator.
- Consumes one requantized int8 result per output channel, as produced by the quant stage after each conv1d computation.
- Packs four results little-endian into 32-bit words and buffers them in a first-word-fall-through FIFO.
- The CPU drains the FIFO one word per pop instead of polling a single accumulator per channel.

Parameters:
INT32_SIZE, 32, data word width
BYTE_SIZE, 8, packed lane width
FIFO_DEPTH, 64, word entries in FIFO; power of two, >= 2
LEVEL_W, $clog2(FIFO_DEPTH)+1, width of level output

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous active-high reset
clear  in  1  synchronous clear of packer, FIFO and flags
in_valid  in  1  result available from quant stage
in_ready  out  1  packer can accept a result this cycle
in_data  in  INT32_SIZE  signed quantized result
flush  in  1  single-cycle request to emit partially filled word
pop  in  1  consume FIFO head
out_data  out  INT32_SIZE  FIFO head word
out_valid  out  1  FIFO non-empty
level  out  LEVEL_W  words currently stored
lane  out  2  bytes held in pack register (0..3)
clip  out  1  sticky: an accepted in_data was outside [-128,127]
underflow  out  1  sticky: pop while out_valid low

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- Reset/clear values: FIFO empty, level=0, lane=0, pack register=0, clip=0, underflow=0, flush_pending=0, out_valid=0, out_data=0, in_ready=1.
  - rst mid-operation discards all stored and partial data immediately.
  - clear does the same on the next edge and has priority over every other input that cycle.
- Accept: handshake completes when in_valid && in_ready on a rising edge.
  - Byte = in_data saturated to [-128,127], low 8 bits.
  - clip sets if saturation changed the value.
- Packing: byte k of a word (k = lane) occupies bits [8k+7:8k]. On accept with lane<3, byte stored and lane increments.
- Word push on lane==3:
  - Accept with lane==3 writes the completed word into the FIFO on that same edge.
  - lane returns to 0 and the pack register clears.
  - Latency from 4th accept to out_valid (if FIFO was empty) is 1 cycle.
- in_ready = !(lane==3 && level==FIFO_DEPTH) && !flush_pending. in_ready does not consider a same-cycle pop: it is registered-safe backpressure, never data loss.
- Flush:
  - With lane>0 and FIFO not full, the partial word is pushed with unused upper bytes = 0, and lane goes to 0.
  - If an accept occurs in the same cycle, that byte is included before flushing. If this completes a full word, it is pushed as a normal word and flush is a no-op.
  - With lane==0 (after any same-cycle accept), flush is a no-op.
  - If the FIFO is full, flush_pending latches. in_ready drops until the partial word is pushed on the first cycle with space.
- FIFO:
  - Circular buffer with read/write pointers wrapping modulo FIFO_DEPTH.
  - out_data shows the head combinationally from storage (FWFT); value is undefined-free (holds last head) when empty.
  - pop with out_valid advances the head.
  - Simultaneous push and pop: level unchanged; both pointers advance. A pop on a full FIFO in the same cycle as a blocked push does not admit the push (in_ready was already low).
  - pop when empty: no pointer change, underflow sets.
- level always equals push count minus pop count, range 0..FIFO_DEPTH; never wraps.
- clip/underflow cleared only by rst or clear.

Test Plan:
- Accept 0x01,0x02,0x03,0x04 back-to-back -> 1 cycle later out_valid=1, out_data=0x04030201, level=1, lane=0; pop -> out_valid=0.
- Accept 300, -200, 5 then flush -> out_data=0x00_05_80_7F, clip=1, lane=0.
- Fill FIFO with 64 words, then accept 3 more bytes -> in_ready stays 1 while lane<3; at lane==3 in_ready=0. One pop -> in_ready=1 next cycle; 4th byte accepted, level=64.
- FIFO full, lane=2, flush -> flush_pending, in_ready=0. Pop -> partial word pushed next edge, in_ready=1, level=64.
- Pop on empty -> underflow=1, level=0. Push 130 words while popping every cycle -> order preserved across pointer wrap, level never exceeds 1.
- Assert rst asynchronously with level=10, lane=2 -> outputs reach reset values before next clk edge. Clear with in_valid, flush and pop all high -> all state cleared, no push.
